// File: rtl/muldiv_pkg.sv
// Shared encodings, FSM states and fixed results for the RV32M multiply/divide unit.
package muldiv_pkg;

    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    localparam logic [31:0] DIV_ZERO_Q   = 32'hFFFF_FFFF;
    localparam logic [31:0] OVF_DIVIDEND = 32'h8000_0000;
    localparam logic [31:0] OVF_DIVISOR  = 32'hFFFF_FFFF;
    localparam logic [31:0] OVF_Q        = 32'h8000_0000;
    localparam logic [31:0] OVF_R        = 32'h0000_0000;

    localparam logic [4:0] ITER_LAST = 5'd31;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } state_t;

    function automatic logic [31:0] neg32(input logic [31:0] v);
        return ~v + 32'd1;
    endfunction

    function automatic logic [63:0] neg64(input logic [63:0] v);
        return ~v + 64'd1;
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shared datapath: shift-add multiply or restoring divide.
module muldiv_step
    import muldiv_pkg::*;
(
    input  logic [63:0] acc,
    input  logic [31:0] operand,
    input  logic        is_div,
    output logic [63:0] acc_next,
    output logic        bit_out
);

    logic [32:0] sum_s;
    logic [32:0] shifted_s;
    logic [32:0] diff_s;

    // acc is {hi, lo}: product halves for multiply, {remainder, dividend/quotient} for divide
    always_comb begin
        sum_s     = 33'd0;
        shifted_s = 33'd0;
        diff_s    = 33'd0;
        acc_next  = acc;
        bit_out   = 1'b0;
        if (is_div) begin
            shifted_s = {acc[63:32], acc[31]};
            diff_s    = shifted_s - {1'b0, operand};
            bit_out   = ~diff_s[32];
            acc_next  = {(diff_s[32] ? shifted_s[31:0] : diff_s[31:0]), acc[30:0], 1'b0};
        end else begin
            sum_s    = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, operand} : 33'd0);
            bit_out  = acc[0];
            acc_next = {sum_s, acc[31:1]};
        end
    end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide for the EX stage; stalls the front end while busy.
// Define MULDIV_FAST_MUL_EN for a single-cycle multiplier (divides stay iterative).
module ex_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            kill,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic [4:0]      rd_in,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out
);

    state_t      state_r;
    logic [2:0]  f3_r;
    logic [4:0]  rd_r;
    logic [63:0] acc_r;
    logic [31:0] opd_r;
    logic        neg_r;
    logic [4:0]  cnt_r;
    logic        done_r;
    logic [31:0] result_r;
    logic [4:0]  rd_out_r;

    logic        a_signed_s, b_signed_s, a_neg_s, b_neg_s, neg_s;
    logic [31:0] a_mag_s, b_mag_s;
    logic        special_s;
    logic [31:0] special_val_s;
    logic        fast_s;
    logic [31:0] fast_val_s;
    logic [63:0] step_acc_s, calc_acc_s, mul_p_s;
    logic        step_bit_s;
    logic [31:0] div_sel_s, fix_val_s;
`ifdef MULDIV_FAST_MUL_EN
    logic signed [65:0] fast_prod_s;
`endif

    // Operand signedness, magnitudes, result sign and early-exit results
    always_comb begin
        a_signed_s = (funct3 == F3_MULH) || (funct3 == F3_MULHSU) ||
                     (funct3 == F3_DIV)  || (funct3 == F3_REM);
        b_signed_s = (funct3 == F3_MULH) || (funct3 == F3_DIV) || (funct3 == F3_REM);
        a_neg_s    = a_signed_s & op_a[31];
        b_neg_s    = b_signed_s & op_b[31];
        a_mag_s    = a_neg_s ? neg32(op_a) : op_a;
        b_mag_s    = b_neg_s ? neg32(op_b) : op_b;
        case (funct3)
            F3_MULH, F3_MULHSU, F3_DIV: neg_s = a_neg_s ^ b_neg_s;
            F3_REM:                     neg_s = a_neg_s;
            default:                    neg_s = 1'b0;
        endcase
        special_s     = 1'b0;
        special_val_s = 32'h0;
        if (funct3[2] && (op_b == 32'h0)) begin
            special_s     = 1'b1;
            special_val_s = funct3[1] ? op_a : DIV_ZERO_Q;
        end else if (((funct3 == F3_DIV) || (funct3 == F3_REM)) &&
                     (op_a == OVF_DIVIDEND) && (op_b == OVF_DIVISOR)) begin
            special_s     = 1'b1;
            special_val_s = funct3[1] ? OVF_R : OVF_Q;
        end else begin
            special_s     = 1'b0;
            special_val_s = 32'h0;
        end
    end

    // Optional single-cycle multiply computed straight from the inputs
    always_comb begin
        fast_s     = 1'b0;
        fast_val_s = 32'h0;
`ifdef MULDIV_FAST_MUL_EN
        fast_prod_s = $signed({a_signed_s & op_a[31], op_a}) *
                      $signed({b_signed_s & op_b[31], op_b});
        fast_s      = ~funct3[2];
        fast_val_s  = (funct3 == F3_MUL) ? fast_prod_s[31:0] : fast_prod_s[63:32];
`endif
    end

    muldiv_step u_step (
        .acc      (acc_r),
        .operand  (opd_r),
        .is_div   (f3_r[2]),
        .acc_next (step_acc_s),
        .bit_out  (step_bit_s)
    );

    assign calc_acc_s = f3_r[2] ? {step_acc_s[63:1], step_bit_s} : step_acc_s;

    // Sign correction and result selection once iteration finishes
    always_comb begin
        mul_p_s   = neg_r ? neg64(acc_r) : acc_r;
        div_sel_s = f3_r[1] ? acc_r[63:32] : acc_r[31:0];
        if (!f3_r[2]) begin
            fix_val_s = (f3_r == F3_MUL) ? mul_p_s[31:0] : mul_p_s[63:32];
        end else begin
            fix_val_s = neg_r ? neg32(div_sel_s) : div_sel_s;
        end
    end

    // Control FSM with registered done/result/rd_out
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r  <= IDLE;
            f3_r     <= 3'b000;
            rd_r     <= 5'd0;
            acc_r    <= 64'd0;
            opd_r    <= 32'd0;
            neg_r    <= 1'b0;
            cnt_r    <= 5'd0;
            done_r   <= 1'b0;
            result_r <= 32'd0;
            rd_out_r <= 5'd0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start && !kill) begin
                        f3_r  <= funct3;
                        rd_r  <= rd_in;
                        neg_r <= neg_s;
                        cnt_r <= ITER_LAST;
                        if (special_s || fast_s) begin
                            acc_r    <= 64'd0;
                            opd_r    <= 32'd0;
                            result_r <= special_s ? special_val_s : fast_val_s;
                            rd_out_r <= rd_in;
                            done_r   <= 1'b1;
                            state_r  <= DONE;
                        end else if (funct3[2]) begin
                            acc_r   <= {32'd0, a_mag_s};
                            opd_r   <= b_mag_s;
                            state_r <= CALC;
                        end else begin
                            acc_r   <= {32'd0, b_mag_s};
                            opd_r   <= a_mag_s;
                            state_r <= CALC;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                CALC: begin
                    if (kill) begin
                        state_r <= IDLE;
                    end else begin
                        acc_r <= calc_acc_s;
                        cnt_r <= cnt_r - 5'd1;
                        if (cnt_r == 5'd0) begin
                            state_r <= FIX;
                        end else begin
                            state_r <= CALC;
                        end
                    end
                end
                FIX: begin
                    if (kill) begin
                        state_r <= IDLE;
                    end else begin
                        result_r <= fix_val_s;
                        rd_out_r <= rd_r;
                        done_r   <= 1'b1;
                        state_r  <= DONE;
                    end
                end
                DONE:    state_r <= IDLE;
                default: state_r <= IDLE;
            endcase
        end
    end

    assign stall  = ((state_r == IDLE) && start && !kill) || (state_r == CALC) || (state_r == FIX);
    assign done   = done_r;
    assign result = result_r;
    assign rd_out = rd_out_r;

endmodule
